// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encodings, FSM states and a field helper for spi_ram_ctrl.
package spi_ram_pkg;
  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;
  localparam int SPI_W = 10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SPI_WR,
    S_SPI_RD,
    S_SPI_RWAIT,
    S_HOST_ACC,
    S_HOST_RWAIT
  } state_t;
  function automatic logic [1:0] cmd_of(input logic [SPI_W-1:0] w);
    return w[SPI_W-1:SPI_W-2];
  endfunction
endpackage

// File: rtl/spi_ram_ctrl_cmd_q.sv
// spi_ram_ctrl_cmd_q: rx_valid rising-edge detector feeding a one-entry pending slot
// with a sticky overflow flag for commands that find the slot occupied.
module spi_ram_ctrl_cmd_q
  import spi_ram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SPI_W-1:0] i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_deq,
  output logic [SPI_W-1:0] o_pend,
  output logic             o_pend_vld,
  output logic             o_edge,
  output logic             o_accept,
  output logic             o_ovf
);
  logic             r_rxv_q;
  logic [SPI_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_ovf;
  logic             w_edge;
  logic             w_accept;
  assign w_edge     = i_rx_valid & ~r_rxv_q;
  // a slot being drained this cycle can take the new word
  assign w_accept   = w_edge & (~r_pend_vld | i_deq);
  assign o_pend     = r_pend;
  assign o_pend_vld = r_pend_vld;
  assign o_edge     = w_edge;
  assign o_accept   = w_accept;
  assign o_ovf      = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxv_q    <= 1'b0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rxv_q <= i_rx_valid;
      if (w_accept) begin
        r_pend     <= i_rx_data;
        r_pend_vld <= 1'b1;
      end else if (i_deq) begin
        r_pend_vld <= 1'b0;
      end
      if (w_edge & ~w_accept) r_ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: sequences SPI words into RAM address/write/read operations and shares the
// RAM port with a parallel host, SPI first. Define SPI_RAM_AUTOINC_EN for address auto-increment.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_W-1:0]      rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ovf
);
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  r_host_rvalid;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [SPI_W-1:0]      w_pend;
  logic                  w_pend_vld;
  logic                  w_edge;
  logic                  w_accept;
  logic                  w_deq;
  logic                  w_host_gnt;
  logic [1:0]            w_cmd;
  logic [ADDR_WIDTH-1:0] w_pay_addr;
  logic [DATA_WIDTH-1:0] w_pay_data;
  spi_ram_ctrl_cmd_q u_cmd_q (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_deq      (w_deq),
    .o_pend     (w_pend),
    .o_pend_vld (w_pend_vld),
    .o_edge     (w_edge),
    .o_accept   (w_accept),
    .o_ovf      (ovf)
  );
  assign w_cmd      = cmd_of(w_pend);
  assign w_pay_addr = w_pend[ADDR_WIDTH-1:0];
  assign w_pay_data = DATA_WIDTH'(w_pend[SPI_W-3:0]);
  assign w_deq      = (r_state == S_IDLE) & w_pend_vld;
  // a word arriving this cycle already outranks the host
  assign w_host_gnt = (r_state == S_IDLE) & ~w_pend_vld & ~w_edge & host_req;
  assign host_gnt    = w_host_gnt;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_host_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_deq) begin
            case (w_cmd)
              CMD_WADDR: r_wr_addr <= w_pay_addr;
              CMD_RADDR: r_rd_addr <= w_pay_addr;
              CMD_WDATA: begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_wr_addr;
                r_mem_wdata <= w_pay_data;
                r_state     <= S_SPI_WR;
`ifdef SPI_RAM_AUTOINC_EN
                r_wr_addr   <= r_wr_addr + ADDR_WIDTH'(1);
`endif
              end
              default: begin
                r_mem_en    <= 1'b1;
                r_mem_addr  <= r_rd_addr;
                r_state     <= S_SPI_RD;
`ifdef SPI_RAM_AUTOINC_EN
                r_rd_addr   <= r_rd_addr + ADDR_WIDTH'(1);
`endif
              end
            endcase
          end else if (w_host_gnt) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= host_we;
            r_mem_addr  <= host_addr;
            r_mem_wdata <= host_wdata;
            r_state     <= S_HOST_ACC;
          end
        end
        S_SPI_WR:    r_state <= S_IDLE;
        S_SPI_RD:    r_state <= S_SPI_RWAIT;
        S_SPI_RWAIT: begin
          r_tx_data  <= mem_rdata;
          r_tx_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_HOST_ACC:  r_state <= r_mem_we ? S_IDLE : S_HOST_RWAIT;
        S_HOST_RWAIT: begin
          r_host_rdata  <= mem_rdata;
          r_host_rvalid <= 1'b1;
          r_state       <= S_IDLE;
        end
        default:     r_state <= S_IDLE;
      endcase
      if (w_accept) r_tx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed and random SPI/host traffic against a behavioural RAM model.
module tb_spi_ram_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       ovf;
  spi_ram_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ovf(ovf)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] ram [256];
  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else mem_rdata <= ram[mem_addr];
  end
  int wr_cnt = 0, en_cyc = -1, tx_rise = -1, rv_cyc = -1;
  logic txv_d = 1'b0;
  always @(negedge clk) begin
    if (mem_en && mem_we) wr_cnt++;
    if (mem_en) en_cyc = cyc;
    if (tx_valid && !txv_d) tx_rise = cyc;
    txv_d = tx_valid;
    if (host_rvalid) rv_cyc = cyc;
  end
  int errors = 0, checks = 0;
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_wa = '0, mdl_ra = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic spi(input logic [1:0] c, input logic [7:0] p, input int hold = 1);
    int t;
    en_cyc = -1;
    tx_rise = -1;
    rx_data = {c, p};
    rx_valid = 1'b1;
    t = cyc;
    step(hold);
    rx_valid = 1'b0;
    step(12);
    case (c)
      2'b00: begin mdl_wa = p; check("txv_clr_wa", tx_valid, 0); end
      2'b10: begin mdl_ra = p; check("txv_clr_ra", tx_valid, 0); end
      2'b01: begin
        mdl_mem[mdl_wa] = p;
        check("wr_lat", en_cyc - t, 2);
        check("ram_wr", ram[mdl_wa], p);
`ifdef SPI_RAM_AUTOINC_EN
        mdl_wa++;
`endif
      end
      default: begin
        check("rd_data", tx_data, mdl_mem[mdl_ra]);
        check("rd_txv", tx_valid, 1);
        check("rd_lat", tx_rise - t, 4);
`ifdef SPI_RAM_AUTOINC_EN
        mdl_ra++;
`endif
      end
    endcase
  endtask
  task automatic host(input logic we, input logic [7:0] a, input logic [7:0] d);
    int g = -1;
    en_cyc = -1;
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_gnt) begin g = cyc; break; end
      step(1);
    end
    step(1);
    host_req = 1'b0;
    if (g < 0) begin
      check("gnt_timeout", 0, 1);
      return;
    end
    step(6);
    check("host_en_lat", en_cyc - g, 1);
    if (we) begin
      mdl_mem[a] = d;
      check("host_wr", ram[a], d);
    end else begin
      check("host_rdata", host_rdata, mdl_mem[a]);
      check("host_rv_lat", rv_cyc - g, 3);
    end
  endtask
  initial begin
    int t, g, w0;
    logic [7:0] exp_a;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; mdl_mem[i] = '0; end
    step(3);
    check("rst_outs", {tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, mem_en, mem_we, ovf}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    rst = 1'b0;
    step(2);
    // basic write/read-back through SPI
    spi(2'b00, 8'h12);
    spi(2'b01, 8'hAB);
    spi(2'b10, 8'h12);
    spi(2'b11, 8'h00);
    check("seq_tx", tx_data, 8'hAB);
    // long rx_valid level: one write only
    w0 = wr_cnt;
    spi(2'b00, 8'h40);
    spi(2'b01, 8'h5C, 20);
    check("one_write", wr_cnt - w0, 1);
    // host read colliding with an SPI write edge
    exp_a = mdl_wa;
    rx_data = {2'b01, 8'h77};
    rx_valid = 1'b1;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = exp_a;
    t = cyc;
    g = -1;
    en_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_gnt) begin g = cyc; break; end
      step(1);
    end
    step(1);
    host_req = 1'b0;
    rx_valid = 1'b0;
    step(6);
    mdl_mem[exp_a] = 8'h77;
`ifdef SPI_RAM_AUTOINC_EN
    mdl_wa++;
`endif
    check("prio_gnt", g - t, 3);
    check("prio_rdata", host_rdata, 8'h77);
    check("prio_rv", rv_cyc - g, 3);
    // overflow: two buffered edges then a third on a full slot
    spi(2'b10, 8'h12);
    rx_data = {2'b11, 8'h00}; rx_valid = 1'b1; step(1); rx_valid = 1'b0; step(1);
    rx_data = {2'b11, 8'h00}; rx_valid = 1'b1; step(1); rx_valid = 1'b0; step(1);
    rx_data = {2'b00, 8'h30}; rx_valid = 1'b1; step(1); rx_valid = 1'b0;
    check("ovf_clear", ovf, 0);
    step(1);
    rx_data = {2'b00, 8'h31}; rx_valid = 1'b1; step(1); rx_valid = 1'b0;
    check("ovf_set", ovf, 1);
    step(10);
`ifdef SPI_RAM_AUTOINC_EN
    mdl_ra = mdl_ra + 8'd2;
    exp_a = mdl_mem[8'h13];
`else
    exp_a = mdl_mem[8'h12];
`endif
    mdl_wa = 8'h30;
    check("ovf_tx", tx_data, exp_a);
    check("ovf_sticky", ovf, 1);
    spi(2'b01, 8'hC3);
    // reset while waiting on read data
    spi(2'b10, 8'h30);
    rx_data = {2'b11, 8'h00}; rx_valid = 1'b1; step(1); rx_valid = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    check("rst_mid", {tx_valid, mem_en, ovf}, 0);
    step(1);
    rst = 1'b0;
    mdl_wa = '0;
    mdl_ra = '0;
    step(2);
    spi(2'b01, 8'h9E);
    spi(2'b11, 8'h00);
`ifdef SPI_RAM_AUTOINC_EN
    spi(2'b00, 8'hFF);
    spi(2'b01, 8'h11);
    spi(2'b01, 8'h22);
    check("inc_ff", ram[8'hFF], 8'h11);
    check("inc_00", ram[8'h00], 8'h22);
`endif
    // random mix of SPI commands and host accesses
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: spi(2'b00, 8'($urandom_range(0, 255)));
        1: spi(2'b10, 8'($urandom_range(0, 255)));
        2, 3: spi(2'($urandom_range(1, 1) | ($urandom_range(0, 1) << 1)), 8'($urandom_range(0, 255)));
        default: host(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      endcase
    end
    check("final_ovf", ovf, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
